// File: rtl/std_mem_d1_copy_if.sv
// Bus bundle between the d1 copy engine, its parent's go/done handshake
// and the source/destination d1 memories.
interface std_mem_d1_copy_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned IDX_SIZE = 4
);
    // Invocation handshake
    logic                go;
    logic [IDX_SIZE:0]   len;
    logic [IDX_SIZE-1:0] src_base;
    logic [IDX_SIZE-1:0] dst_base;
    logic                busy;
    logic [IDX_SIZE:0]   count;
    logic                done;

    // Source memory (combinational read)
    logic [IDX_SIZE-1:0] src_addr0;
    logic [WIDTH-1:0]    src_read_data;

    // Destination memory
    logic [IDX_SIZE-1:0] dst_addr0;
    logic [WIDTH-1:0]    dst_write_data;
    logic                dst_write_en;
    logic                dst_done;

    // Copy engine side
    modport master (
        input  go, len, src_base, dst_base, src_read_data, dst_done,
        output busy, count, done, src_addr0, dst_addr0, dst_write_data, dst_write_en
    );

    // Parent / memory side
    modport slave (
        output go, len, src_base, dst_base, src_read_data, dst_done,
        input  busy, count, done, src_addr0, dst_addr0, dst_write_data, dst_write_en
    );
endinterface

// File: rtl/std_mem_d1_copy.sv
// Copies len words from a source d1 memory to a destination d1 memory,
// one read/write/ack round per word, under a go/done handshake.
module std_mem_d1_copy #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SIZE     = 16,
    parameter int unsigned IDX_SIZE = 4
) (
    input logic               clk,
    input logic               reset,
    std_mem_d1_copy_if.master bus_io
);

    localparam int unsigned LenW = IDX_SIZE + 1;
    localparam logic [IDX_SIZE:0] MaxLen = LenW'(SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StWait,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_SIZE:0]   len_q, len_d;
    logic [IDX_SIZE:0]   idx_q, idx_d;
    logic [IDX_SIZE:0]   count_q, count_d;
    logic [IDX_SIZE-1:0] src_q, src_d;
    logic [IDX_SIZE-1:0] dst_q, dst_d;
    logic [WIDTH-1:0]    data_q, data_d;

    logic [IDX_SIZE:0]   len_clamped;
    logic [IDX_SIZE:0]   idx_inc;
    logic [IDX_SIZE-1:0] idx_lo;

    assign len_clamped = (bus_io.len > MaxLen) ? MaxLen : bus_io.len;
    assign idx_inc     = idx_q + 1'b1;
    assign idx_lo      = idx_q[IDX_SIZE-1:0];

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        count_d = count_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.go) begin
                    len_d   = len_clamped;
                    src_d   = bus_io.src_base;
                    dst_d   = bus_io.dst_base;
                    idx_d   = '0;
                    count_d = '0;
                    state_d = (len_clamped == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                data_d  = bus_io.src_read_data;
                state_d = StWrite;
            end
            StWrite: begin
                state_d = StWait;
            end
            StWait: begin
                // No timeout: a stalled destination parks the engine here
                if (bus_io.dst_done) begin
                    idx_d   = idx_inc;
                    count_d = count_q + 1'b1;
                    state_d = (idx_inc == len_q) ? StDone : StRead;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
        end
    end

    // Addresses wrap modulo the address space
    assign bus_io.src_addr0      = src_q + idx_lo;
    assign bus_io.dst_addr0      = dst_q + idx_lo;
    assign bus_io.dst_write_data = data_q;
    assign bus_io.dst_write_en   = (state_q == StWrite);
    assign bus_io.busy           = (state_q != StIdle);
    assign bus_io.done           = (state_q == StDone);
    assign bus_io.count          = count_q;

endmodule

// File: tb/tb_std_mem_d1_copy.sv
// Randomized bench for std_mem_d1_copy: behavioural memories plus an
// array-based reference of the expected copy result and timing.
module tb_std_mem_d1_copy;

    localparam int WIDTH = 32;
    localparam int SIZE  = 16;
    localparam int IDX   = 4;

    logic clk;
    logic rst_n;

    std_mem_d1_copy_if #(.WIDTH(WIDTH), .IDX_SIZE(IDX)) bus ();

    std_mem_d1_copy #(
        .WIDTH   (WIDTH),
        .SIZE    (SIZE),
        .IDX_SIZE(IDX)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] src_mem [SIZE];
    logic [WIDTH-1:0] dst_mem [SIZE];
    logic [WIDTH-1:0] exp_mem [SIZE];

    int n_checks = 0;
    int n_fail   = 0;

    // Destination responder state
    int wr_cnt     = 0;
    int done_cnt   = 0;
    int stall_word = -1;
    int stall_cyc  = 0;
    int stall_bad  = 0;
    int pend       = 0;
    int delay      = 0;
    int wr_addrs[$];

    assign bus.src_read_data = src_mem[bus.src_addr0];

    // Memory side sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (!rst_n) begin
            pend         = 0;
            bus.dst_done = 1'b0;
        end else if (bus.dst_write_en === 1'b1) begin
            dst_mem[bus.dst_addr0] = bus.dst_write_data;
            wr_addrs.push_back(int'(bus.dst_addr0));
            delay        = (wr_cnt == stall_word) ? stall_cyc : 0;
            wr_cnt++;
            pend         = 1;
            bus.dst_done = 1'b0;
        end else if (pend != 0) begin
            if (bus.busy !== 1'b1) stall_bad++;
            if (delay == 0) begin
                bus.dst_done = 1'b1;
                pend         = 0;
            end else begin
                delay--;
                bus.dst_done = 1'b0;
            end
        end else begin
            bus.dst_done = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic fill_mems();
        for (int i = 0; i < SIZE; i++) begin
            src_mem[i] = $urandom;
            dst_mem[i] = $urandom;
        end
    endtask

    // One transfer: model the expected result, run it, compare everything
    task automatic run_copy(input string name, input int len, input int src, input int dst,
                            input int st_w, input int st_c, input bit mid_go);
        int n;
        int cyc;
        int exp_lat;
        int d0;
        n = (len > SIZE) ? SIZE : len;
        exp_mem = dst_mem;
        for (int i = 0; i < n; i++) exp_mem[(dst + i) % SIZE] = src_mem[(src + i) % SIZE];
        exp_lat = 3 * n + 1 + ((st_w >= 0 && st_w < n) ? st_c : 0);

        stall_word = st_w;
        stall_cyc  = st_c;
        stall_bad  = 0;
        wr_cnt     = 0;
        wr_addrs.delete();
        d0 = done_cnt;

        @(negedge clk);
        bus.go       = 1'b1;
        bus.len      = 5'(len);
        bus.src_base = 4'(src);
        bus.dst_base = 4'(dst);
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 400) begin
            if (mid_go && cyc == 4) begin
                bus.go       = 1'b1;
                bus.len      = 5'd2;
                bus.src_base = 4'(src + 3);
                bus.dst_base = 4'(dst + 5);
            end
            if (cyc == 7) bus.go = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.go = 1'b0;
        check_eq({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        check_eq({name, "_count"}, 32'(bus.count), 32'(n));
        @(posedge clk);
        #1;
        check_eq({name, "_done_pulse"}, 32'(bus.done), 32'd0);
        check_eq({name, "_idle"}, 32'(bus.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check_eq({name, "_writes"}, 32'(wr_cnt), 32'(n));
        check_eq({name, "_count_hold"}, 32'(bus.count), 32'(n));
        check_eq({name, "_stall_busy"}, 32'(stall_bad), 32'd0);
        for (int i = 0; i < wr_addrs.size() && i < n; i++)
            check_eq($sformatf("%s_waddr%0d", name, i), 32'(wr_addrs[i]), 32'((dst + i) % SIZE));
        for (int i = 0; i < SIZE; i++)
            check_eq($sformatf("%s_dst%0d", name, i), dst_mem[i], exp_mem[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        rst_n        = 1'b0;
        bus.go       = 1'b0;
        bus.len      = '0;
        bus.src_base = '0;
        bus.dst_base = '0;
        bus.dst_done = 1'b0;
        fill_mems();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_wen", 32'(bus.dst_write_en), 32'd0);
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_saddr", 32'(bus.src_addr0), 32'd0);
        check_eq("rst_daddr", 32'(bus.dst_addr0), 32'd0);
        check_eq("rst_wdata", bus.dst_write_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic copy
        src_mem[0] = 32'd11;
        src_mem[1] = 32'd22;
        src_mem[2] = 32'd33;
        src_mem[3] = 32'd44;
        run_copy("basic", 4, 0, 8, -1, 0, 1'b0);
        check_eq("basic_d8", dst_mem[8], 32'd11);
        check_eq("basic_d11", dst_mem[11], 32'd44);

        fill_mems();
        run_copy("zero", 0, 3, 5, -1, 0, 1'b0);

        fill_mems();
        run_copy("wrap", 4, 14, 0, -1, 0, 1'b0);

        fill_mems();
        run_copy("stall", 3, 2, 6, 1, 5, 1'b0);

        fill_mems();
        run_copy("clamp", 20, 0, 0, -1, 0, 1'b1);

        // Reset in the WAIT cycle of the first word
        fill_mems();
        stall_word = 0;
        stall_cyc  = 50;
        wr_cnt     = 0;
        @(negedge clk);
        bus.go       = 1'b1;
        bus.len      = 5'd4;
        bus.src_base = 4'd1;
        bus.dst_base = 4'd2;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst_count", 32'(bus.count), 32'd0);
        check_eq("mid_rst_wdata", bus.dst_write_data, 32'd0);
        check_eq("mid_rst_daddr", 32'(bus.dst_addr0), 32'd0);
        w0 = wr_cnt;
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("mid_rst_nowrite", 32'(wr_cnt), 32'(w0));
        check_eq("mid_rst_nodone", 32'(done_cnt), 32'(d0));
        fill_mems();
        run_copy("post_rst", 2, 9, 3, -1, 0, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 8; t++) begin
            fill_mems();
            run_copy($sformatf("rnd%0d", t), int'($urandom_range(0, 20)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/std_mem_d1_copy.md
Name: std_mem_d1_copy

Overview:
- Initiator-side engine for the one-dimensional memory interface (addr0 / write_data / write_en / read_data / done).
- Copies a block of LEN words from a source d1 memory to a destination d1 memory, one word at a time.
- Started with a go/done handshake, so a Calyx component can invoke it like any other sequential cell.
- Replaces hand-written read/write loops in generated control.

Parameters:
- WIDTH, 32, data word width of both memories.
- SIZE, 16, number of words in each attached memory.
- IDX_SIZE, 4, address width; SIZE <= 2^IDX_SIZE.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- go  input  1  start request; sampled only in IDLE.
- len  input  IDX_SIZE+1  number of words to copy; sampled with go.
- src_base  input  IDX_SIZE  first source address; sampled with go.
- dst_base  input  IDX_SIZE  first destination address; sampled with go.
- src_addr0  output  IDX_SIZE  source memory address.
- src_read_data  input  WIDTH  source memory combinational read data.
- dst_addr0  output  IDX_SIZE  destination memory address.
- dst_write_data  output  WIDTH  destination write data.
- dst_write_en  output  1  destination write strobe.
- dst_done  input  1  destination write acknowledge, arrives the cycle after write_en.
- busy  output  1  high in every state except IDLE.
- count  output  IDX_SIZE+1  words written so far in the current or last transfer.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; idx, count, data_q and all latched inputs cleared to 0.
  - All outputs 0.
  - Reset mid-transfer abandons the copy with no further write_en, even if dst_done is pending.
- Registered state: len_q, src_q, dst_q, idx, data_q.
  - src_addr0 = src_q+idx and dst_addr0 = dst_q+idx, both truncated to IDX_SIZE bits (wrap modulo 2^IDX_SIZE).
- Length rule: len_q = min(len, SIZE).
- FSM states and transitions:
  - IDLE: if go=1, latch len/src_base/dst_base, set idx=0 and count=0. Go to DONE if the clamped len is 0, else to READ. go=0 stays in IDLE.
  - READ: drive src_addr0; at the edge capture src_read_data into data_q; go to WRITE. dst_write_en=0.
  - WRITE: dst_write_en=1 for exactly one cycle; dst_addr0 = dst_q+idx; dst_write_data = data_q; go to WAIT.
  - WAIT: dst_write_en=0. Hold until dst_done=1. On dst_done, count<=count+1 and idx<=idx+1. Go to DONE if idx+1==len_q, else to READ.
  - DONE: done=1 for this single cycle; go to IDLE.
- Latency: 3 cycles per word plus 2 cycles overhead (IDLE accept, DONE).
  - len=N with dst_done on the first WAIT cycle: done is asserted 3N+1 cycles after the go-sampling edge.
  - len=0: done is asserted the cycle after go is accepted.
- go handling:
  - go is ignored while busy=1; inputs changing mid-transfer have no effect.
  - go high in the IDLE cycle right after DONE starts a new transfer (parent is expected to drop go after done).
- dst_done outside WAIT is ignored.
- WAIT has no timeout; a stalled destination holds the FSM in WAIT indefinitely with busy=1.
- Outputs dst_addr0 and dst_write_data are don't-care when dst_write_en=0, but must not be X after reset.
- count holds its final value after DONE until the next accepted go.
- Overlapping source and destination ranges copy in ascending index order; no hazard protection.

Test Plan:
- Basic copy: src mem [0..3] = {11,22,33,44}, go with len=4, src_base=0, dst_base=8 -> dst[8..11] = {11,22,33,44}; exactly 4 write_en pulses; done at cycle 13 after accept; count=4.
- Zero length: go with len=0 -> done pulses the cycle after accept; no dst_write_en; count=0.
- Address wrap: SIZE=16, src_base=14, len=4 -> reads addr 14,15,0,1; dst_base=0 -> writes addr 0..3 in order.
- Stalled ack: dst_done delayed 5 cycles on word 2 of len=3 -> FSM holds in WAIT, write_en not reasserted, busy=1; final done at cycle 15 after accept.
- Reset mid-transfer: assert reset=0 in WAIT of word 1 of len=4 -> all outputs 0 immediately; no further writes; done never pulses. After release, a new go with len=2 completes normally.
- Clamp and ignore: len=20 with SIZE=16 -> 16 words copied, count=16. A second go pulse mid-transfer is ignored, giving a single done pulse.
